// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage: execute stage with a combinational ALU and branch unit plus an
// iterative RV32M-style multiply/divide unit (one bit per cycle).
// Latency: ALU/branch 0 cycles; mul/div XLEN+1 cycles from md_start to md_valid.
// Backpressure: stall freezes upstream while a mul/div is being accepted or computed.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   read_data_1/2     - register operands; fwd_ex_mem/fwd_mem_wb with ForwardA/B select bypass
//   imm, ALUSrc       - immediate and operand-B select for the ALU
//   alu_op            - ALU opcode -> ALU_result; store_data is forwarded operand B
//   inst_addr, Branch, br_funct3 -> branch_addr, PCSrc, IF_flush, ID_flush
//   md_start, md_op, md_kill     -> md_result, md_valid, stall
//
// Build option: define EX_MULDIV_DIV_EN to include the divider (DIV/DIVU/REM/REMU).
// Without it, md_op >= 4 completes in one cycle with md_result 0.
module ex_muldiv_stage #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       read_data_1,
    input  logic [XLEN-1:0]       read_data_2,
    input  logic [XLEN-1:0]       imm,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  ALUSrc,
    input  logic [3:0]            alu_op,
    input  logic                  Branch,
    input  logic [2:0]            br_funct3,
    input  logic [1:0]            ForwardA,
    input  logic [1:0]            ForwardB,
    input  logic [XLEN-1:0]       fwd_ex_mem,
    input  logic [XLEN-1:0]       fwd_mem_wb,
    input  logic                  md_start,
    input  logic [2:0]            md_op,
    input  logic                  md_kill,
    output logic [XLEN-1:0]       ALU_result,
    output logic [XLEN-1:0]       store_data,
    output logic [ADDR_WIDTH-1:0] branch_addr,
    output logic                  PCSrc,
    output logic                  IF_flush,
    output logic                  ID_flush,
    output logic [XLEN-1:0]       md_result,
    output logic                  md_valid,
    output logic                  stall
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef EX_MULDIV_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    // MULH, MULHSU, DIV, REM treat operand A as signed
    function automatic logic a_signed_f(input logic [2:0] op);
        return (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    endfunction

    // MULH, DIV, REM treat operand B as signed
    function automatic logic b_signed_f(input logic [2:0] op);
        return (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    endfunction

    // ---------------- forwarding, ALU, branch ----------------
    logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_op_b, w_alu;
    logic [SHW-1:0]  w_shamt;
    logic            w_cond, w_take;

    always_comb begin
        w_fwd_a = (ForwardA == 2'b10) ? fwd_ex_mem :
                  (ForwardA == 2'b01) ? fwd_mem_wb : read_data_1;
        w_fwd_b = (ForwardB == 2'b10) ? fwd_ex_mem :
                  (ForwardB == 2'b01) ? fwd_mem_wb : read_data_2;
        w_op_b  = ALUSrc ? imm : w_fwd_b;
        w_shamt = w_op_b[SHW-1:0];
        case (alu_op)
            4'd0:    w_alu = w_fwd_a + w_op_b;
            4'd1:    w_alu = w_fwd_a - w_op_b;
            4'd2:    w_alu = w_fwd_a & w_op_b;
            4'd3:    w_alu = w_fwd_a | w_op_b;
            4'd4:    w_alu = w_fwd_a ^ w_op_b;
            4'd5:    w_alu = w_fwd_a << w_shamt;
            4'd6:    w_alu = w_fwd_a >> w_shamt;
            4'd7:    w_alu = XLEN'($signed(w_fwd_a) >>> w_shamt);
            4'd8:    w_alu = XLEN'($signed(w_fwd_a) < $signed(w_op_b));
            4'd9:    w_alu = XLEN'(w_fwd_a < w_op_b);
            default: w_alu = '0;
        endcase
    end

    // Branch compares the forwarded register operands, never the immediate
    always_comb begin
        case (br_funct3)
            3'b000:  w_cond = (w_fwd_a == w_fwd_b);
            3'b001:  w_cond = (w_fwd_a != w_fwd_b);
            3'b100:  w_cond = ($signed(w_fwd_a) <  $signed(w_fwd_b));
            3'b101:  w_cond = ($signed(w_fwd_a) >= $signed(w_fwd_b));
            3'b110:  w_cond = (w_fwd_a <  w_fwd_b);
            3'b111:  w_cond = (w_fwd_a >= w_fwd_b);
            default: w_cond = 1'b0;
        endcase
        w_take = Branch & w_cond;
    end

    assign ALU_result  = w_alu;
    assign store_data  = w_fwd_b;
    assign branch_addr = inst_addr + ADDR_WIDTH'($signed(imm));
    assign PCSrc       = w_take;
    assign IF_flush    = w_take;
    assign ID_flush    = w_take;

    // ---------------- multiply / divide ----------------
    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_a, r_b, r_md_result;
    logic [2:0]        r_op;
    logic [2*XLEN-1:0] r_acc;

    logic              w_ra_neg, w_rb_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic [2*XLEN-1:0] w_acc_cur;

    assign w_ra_neg = a_signed_f(r_op) & r_a[XLEN-1];
    assign w_rb_neg = b_signed_f(r_op) & r_b[XLEN-1];
    assign w_a_mag  = w_ra_neg ? -r_a : r_a;
    assign w_b_mag  = w_rb_neg ? -r_b : r_b;
    // First iteration loads |A| into the low half (multiplier or dividend)
    assign w_acc_cur = (r_cnt == '0) ? {{XLEN{1'b0}}, w_a_mag} : r_acc;

    // Shift-add: conditionally add |B| into the high half, then shift right
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_nxt, w_prod;
    logic [XLEN-1:0]   w_mul_res;

    assign w_mul_sum = {1'b0, w_acc_cur[2*XLEN-1:XLEN]} +
                       (w_acc_cur[0] ? {1'b0, w_b_mag} : {(XLEN+1){1'b0}});
    assign w_mul_nxt = {w_mul_sum, w_acc_cur[XLEN-1:1]};
    assign w_prod    = (w_ra_neg ^ w_rb_neg) ? -w_mul_nxt : w_mul_nxt;
    assign w_mul_res = (r_op == 3'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

`ifdef EX_MULDIV_DIV_EN
    // Restoring division: acc = {remainder, dividend/quotient}
    logic [XLEN:0]     w_div_shift, w_div_diff;
    logic [2*XLEN-1:0] w_div_nxt;
    logic [XLEN-1:0]   w_quo, w_rem, w_q_fix, w_r_fix, w_div_res;

    assign w_div_shift = w_acc_cur[2*XLEN-1:XLEN-1];
    assign w_div_diff  = w_div_shift - {1'b0, w_b_mag};
    assign w_div_nxt   = {(w_div_diff[XLEN] ? w_div_shift[XLEN-1:0] : w_div_diff[XLEN-1:0]),
                          w_acc_cur[XLEN-2:0], ~w_div_diff[XLEN]};
    assign w_quo       = w_div_nxt[XLEN-1:0];
    assign w_rem       = w_div_nxt[2*XLEN-1:XLEN];
    // Divide by zero forces quotient -1; remainder naturally equals |dividend|
    assign w_q_fix     = (r_b == '0) ? '1 : ((w_ra_neg ^ w_rb_neg) ? -w_quo : w_quo);
    assign w_r_fix     = w_ra_neg ? -w_rem : w_rem;
    assign w_div_res   = r_op[1] ? w_r_fix : w_q_fix;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_acc       <= '0;
            r_md_result <= '0;
        end else if (md_kill) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (md_start) begin
                        r_a   <= w_fwd_a;
                        r_b   <= w_fwd_b;
                        r_op  <= md_op;
                        r_cnt <= '0;
                        if (!md_op[2]) begin
                            r_state <= S_MUL;
                        end else begin
`ifdef EX_MULDIV_DIV_EN
                            r_state <= S_DIV;
`else
                            r_state     <= S_DONE;
                            r_md_result <= '0;
`endif
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(XLEN-1)) begin
                        r_state     <= S_DONE;
                        r_md_result <= w_mul_res;
                    end
                end
`ifdef EX_MULDIV_DIV_EN
                S_DIV: begin
                    r_acc <= w_div_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(XLEN-1)) begin
                        r_state     <= S_DONE;
                        r_md_result <= w_div_res;
                    end
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign md_result = r_md_result;
    assign md_valid  = (r_state == S_DONE);
`ifdef EX_MULDIV_DIV_EN
    assign stall = ((r_state == S_IDLE) && md_start) || (r_state == S_MUL) || (r_state == S_DIV);
`else
    assign stall = ((r_state == S_IDLE) && md_start) || (r_state == S_MUL);
`endif

endmodule
